// File: rtl/stoch_bin_acc.sv
// Stochastic-to-binary converter: counts the ones in a unipolar bitstream over a
// window of 2^WIDTH valid samples and returns the (saturated) count via valid/ready.
module stoch_bin_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value held before the 2^WIDTH-th sample is accepted.
  localparam logic [WIDTH:0] CNT_LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] ZERO     = {(WIDTH+1){1'b0}};

  state_t           state_r;
  logic [WIDTH:0]   cnt_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH:0]   acc_inc_s;
  logic [WIDTH-1:0] out_r;
  logic             busy_r;
  logic             out_valid_r;

  // An all-ones window overflows WIDTH bits; clamp it to the largest code.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] v);
    if (v[WIDTH]) begin
      return {WIDTH{1'b1}};
    end else begin
      return v[WIDTH-1:0];
    end
  endfunction

  // Accumulator value including the current input bit.
  always_comb begin
    acc_inc_s = acc_r + {{WIDTH{1'b0}}, in};
  end

  // Window FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO;
      acc_r       <= ZERO;
      out_r       <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            cnt_r   <= ZERO;
            acc_r   <= ZERO;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt_r <= cnt_r + ONE;
            acc_r <= acc_inc_s;
            if (cnt_r == CNT_LAST) begin
              out_r       <= saturate(acc_inc_s);
              state_r     <= DONE;
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          // Handshake with start chains straight into the next window.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (start) begin
              state_r <= RUN;
              cnt_r   <= ZERO;
              acc_r   <= ZERO;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= ZERO;
          acc_r       <= ZERO;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

endmodule

// File: tb/tb_stoch_bin_acc.sv
// Directed bench for stoch_bin_acc (WIDTH=4): table of windows plus hand-written
// sequences for backpressure, chained start, start-in-RUN and asynchronous reset.
module tb_stoch_bin_acc;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0]  bits;
    int           gap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  stoch_bin_acc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in(in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start is raised with in_valid=1/in=1; IDLE must ignore that sample.
  task automatic do_start();
    start = 1'b1; in_valid = 1'b1; in = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0; in = 1'b0;
  endtask

  // Feeds n samples; ok stays 1 only if every cycle showed busy=1 and out_valid=0.
  task automatic feed(input logic [15:0] bits, input int n, input int gap,
                      input int start_at, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; in = 1'b1; start = 1'b0;
        if (busy !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
        step();
      end
      in_valid = 1'b1; in = bits[i]; start = (i == start_at);
      if (busy !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
      step();
    end
    in_valid = 1'b0; in = 1'b0; start = 1'b0;
  endtask

  task automatic handshake_idle(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_ov_after_hs"}, {31'd0, out_valid}, 32'd0);
    check({name, "_busy_after_hs"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit ok;
    bit stable;

    vecs[0] = '{bits: 16'hFFFF, gap: 0, exp: 4'd15};
    vecs[1] = '{bits: 16'hAAAA, gap: 0, exp: 4'd8};
    vecs[2] = '{bits: 16'h0000, gap: 0, exp: 4'd0};
    vecs[3] = '{bits: 16'hFFFE, gap: 0, exp: 4'd15};
    vecs[4] = '{bits: 16'h7FFF, gap: 0, exp: 4'd15};
    vecs[5] = '{bits: 16'h0001, gap: 0, exp: 4'd1};
    vecs[6] = '{bits: 16'h00FF, gap: 0, exp: 4'd8};
    vecs[7] = '{bits: 16'hFFFF, gap: 2, exp: 4'd15};
    vecs[8] = '{bits: 16'h1234, gap: 1, exp: 4'd5};

    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {28'd0, out}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      do_start();
      feed(vecs[v].bits, N, vecs[v].gap, -1, ok);
      check($sformatf("vec%0d_running", v), {31'd0, ok}, 32'd1);
      check($sformatf("vec%0d_out_valid", v), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_busy_done", v), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_out", v), {28'd0, out}, {28'd0, vecs[v].exp});
      handshake_idle($sformatf("vec%0d", v));
    end

    // Backpressure: hold out_ready low for 10 cycles, pulse start mid-stall.
    do_start();
    feed(16'h00FF, N, 0, -1, ok);
    check("bp_running", {31'd0, ok}, 32'd1);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      if (out_valid !== 1'b1 || out !== 4'd8 || busy !== 1'b0) stable = 1'b0;
      step();
    end
    start = 1'b0;
    check("bp_stall_stable", {31'd0, stable}, 32'd1);
    check("bp_out_held", {28'd0, out}, 32'd8);
    handshake_idle("bp_release");
    step();
    check("bp_start_not_latched", {31'd0, busy}, 32'd0);

    // Handshake together with start: RUN next cycle, handshake-cycle sample dropped.
    do_start();
    feed(16'hFFFF, N, 0, -1, ok);
    check("chain_first_out", {28'd0, out}, 32'd15);
    out_ready = 1'b1; start = 1'b1; in_valid = 1'b1; in = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0; in = 1'b0;
    check("chain_busy_next", {31'd0, busy}, 32'd1);
    check("chain_ov_next", {31'd0, out_valid}, 32'd0);
    feed(16'h0000, N, 0, -1, ok);
    check("chain_running", {31'd0, ok}, 32'd1);
    check("chain_second_ov", {31'd0, out_valid}, 32'd1);
    check("chain_second_out", {28'd0, out}, 32'd0);
    handshake_idle("chain");

    // Start pulse at sample 5 must neither restart nor shorten the window.
    do_start();
    feed(16'hF0F0, N, 0, 5, ok);
    check("startrun_running", {31'd0, ok}, 32'd1);
    check("startrun_ov", {31'd0, out_valid}, 32'd1);
    check("startrun_out", {28'd0, out}, 32'd8);
    handshake_idle("startrun");

    // Asynchronous reset while sample 9 is on the bus.
    do_start();
    feed(16'hFFFF, 8, 0, -1, ok);
    in_valid = 1'b1; in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out", {28'd0, out}, 32'd0);
    in_valid = 1'b0; in = 1'b0;
    #10 rst_n = 1'b1;
    step();
    check("arst_idle_after", {31'd0, busy}, 32'd0);
    do_start();
    feed(16'h0000, N, 0, -1, ok);
    check("arst_zero_running", {31'd0, ok}, 32'd1);
    check("arst_zero_ov", {31'd0, out_valid}, 32'd1);
    check("arst_zero_out", {28'd0, out}, 32'd0);
    handshake_idle("arst_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
